// File: rtl/lm96570_spi_pkg.sv
// Register map, control/status bit positions and FSM encodings for the LM96570 SPI master.
// No logic of its own; constants and a length-clamp helper only.
// Not applicable: contains no datapath.
package lm96570_spi_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_DIV   = 3'd1;
  localparam logic [2:0] ADDR_TX_LO = 3'd2;
  localparam logic [2:0] ADDR_TX_HI = 3'd3;
  localparam logic [2:0] ADDR_RX_LO = 3'd4;
  localparam logic [2:0] ADDR_RX_HI = 3'd5;

  // CTRL (write) bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLEAR    = 2;
  localparam int CTRL_LEN_LSB  = 8;
  localparam int CTRL_MASK_LSB = 16;

  // STATUS (read) bit positions
  localparam int STAT_BUSY   = 0;
  localparam int STAT_IRQ_EN = 1;
  localparam int STAT_DONE   = 2;
  localparam int STAT_ERR    = 3;

  // Transfer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  // Frame length from the LEN-1 field, limited to the widest frame the engine holds
  function automatic logic [6:0] clamp_len(input logic [5:0] len_m1, input logic [6:0] max_len);
    logic [6:0] len;
    len = {1'b0, len_m1} + 7'd1;
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/lm96570_spi_clkgen.sv
// Half-period timer: pulses tick for one clk every DIV+1 cycles while enabled.
// Latency: first tick DIV+1 cycles after clr/enable; counter restarts on every tick.
// No backpressure; runs freely while en is high, held at zero otherwise.
module lm96570_spi_clkgen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = en && (cnt == div);

  // Count clk cycles within the current half period; restart at each tick or on clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/lm96570_spi_master.sv
// Avalon-MM SPI master shifting LSB-first configuration frames into LM96570 beamformers.
// Latency: BUSY/cs_n one edge after START; frame takes H*(2*LEN+2) cycles, H = DIV+1.
// No backpressure: zero-wait slave; writes to DIV/TX while busy are dropped, START while busy flags ERR.
// Build option: define LM96570_SPI_READBACK_EN to build the sdi capture path and RX registers.
module lm96570_spi_master
  import lm96570_spi_pkg::*;
#(
  parameter int NUM_CS      = 4,
  parameter int FRAME_MAX_W = 64,
  parameter int DIV_RST     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi,
  output logic [NUM_CS-1:0] cs_n
);

  localparam logic [15:0] DIV_RST_V = 16'(DIV_RST);
  localparam logic [6:0]  LEN_MAX   = 7'(FRAME_MAX_W);

  // Register file and engine state
  state_t                 state, state_nxt;
  logic                   busy, busy_nxt;
  logic                   irq_en, irq_en_nxt;
  logic                   done, done_nxt;
  logic                   err, err_nxt;
  logic [5:0]             len_m1, len_m1_nxt;
  logic [NUM_CS-1:0]      mask, mask_nxt;
  logic [15:0]            div, div_nxt;
  logic [FRAME_MAX_W-1:0] tx, tx_nxt;
  logic [15:0]            div_lat, div_lat_nxt;
  logic [6:0]             len_lat, len_lat_nxt;
  logic [FRAME_MAX_W-1:0] tx_sh, tx_sh_nxt;
  logic [7:0]             hcnt, hcnt_nxt;
  logic                   sclk_nxt, sdo_nxt, irq_nxt;
  logic [NUM_CS-1:0]      cs_n_nxt;
`ifdef LM96570_SPI_READBACK_EN
  logic [FRAME_MAX_W-1:0] rx, rx_nxt;
`endif

  logic              wr, wr_ctrl, ctrl_start, start_ok, tick;
  logic [NUM_CS-1:0] wr_mask;
  logic [7:0]        last_half, hcnt_inc;
  logic              unused_bits;

  assign wr         = chipselect && !write_n;
  assign wr_ctrl    = wr && (address == ADDR_CTRL);
  assign ctrl_start = writedata[CTRL_START];
  assign wr_mask    = writedata[CTRL_MASK_LSB +: NUM_CS];
  assign start_ok   = wr_ctrl && ctrl_start && !busy && (wr_mask != '0);
  assign last_half  = {len_lat, 1'b0} - 8'd1;
  assign hcnt_inc   = hcnt + 8'd1;

`ifdef LM96570_SPI_READBACK_EN
  assign unused_bits = ^writedata;
`else
  assign unused_bits = ^{writedata, sdi};
`endif

  lm96570_spi_clkgen u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_ok),
    .en      (busy),
    .div     (div_lat),
    .tick    (tick)
  );

  // Next-state logic: shift engine advances on ticks, then bus writes are applied on top
  always_comb begin
    state_nxt   = state;
    busy_nxt    = busy;
    irq_en_nxt  = irq_en;
    done_nxt    = done;
    err_nxt     = err;
    len_m1_nxt  = len_m1;
    mask_nxt    = mask;
    div_nxt     = div;
    tx_nxt      = tx;
    div_lat_nxt = div_lat;
    len_lat_nxt = len_lat;
    tx_sh_nxt   = tx_sh;
    hcnt_nxt    = hcnt;
    sclk_nxt    = sclk;
    sdo_nxt     = sdo;
    cs_n_nxt    = cs_n;
`ifdef LM96570_SPI_READBACK_EN
    rx_nxt      = rx;
`endif

    if (tick) begin
      case (state)
        ST_SETUP: begin
          // First rising edge: bit 0 already on sdo
          state_nxt = ST_SHIFT;
          sclk_nxt  = 1'b1;
          hcnt_nxt  = '0;
`ifdef LM96570_SPI_READBACK_EN
          rx_nxt[0] = sdi;
`endif
        end
        ST_SHIFT: begin
          if (hcnt == last_half) begin
            // Low half after the final falling edge has elapsed
            state_nxt = ST_GAP;
            sclk_nxt  = 1'b0;
            cs_n_nxt  = '1;
          end else begin
            hcnt_nxt = hcnt_inc;
            sclk_nxt = ~sclk;
            if (sclk) begin
              // Falling edge: present the next bit
              tx_sh_nxt = tx_sh >> 1;
              sdo_nxt   = tx_sh[1];
            end else begin
`ifdef LM96570_SPI_READBACK_EN
              // Rising edge n captures readback bit n (hcnt_inc = 2n)
              rx_nxt[hcnt_inc[6:1]] = sdi;
`endif
            end
          end
        end
        ST_GAP: begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
        default: ;
      endcase
    end

    if (wr_ctrl) begin
      if (busy && ctrl_start) begin
        err_nxt = 1'b1;
      end else begin
        irq_en_nxt = writedata[CTRL_IRQ_EN];
        if (writedata[CTRL_CLEAR]) begin
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
        end
        len_m1_nxt = writedata[CTRL_LEN_LSB +: 6];
        mask_nxt   = wr_mask;
        if (ctrl_start) begin
          if (wr_mask == '0) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt   = ST_SETUP;
            busy_nxt    = 1'b1;
            div_lat_nxt = div;
            len_lat_nxt = clamp_len(writedata[CTRL_LEN_LSB +: 6], LEN_MAX);
            tx_sh_nxt   = tx;
            sdo_nxt     = tx[0];
            sclk_nxt    = 1'b0;
            cs_n_nxt    = ~wr_mask;
            hcnt_nxt    = '0;
`ifdef LM96570_SPI_READBACK_EN
            rx_nxt      = '0;
`endif
          end
        end
      end
    end

    if (wr && !busy) begin
      case (address)
        ADDR_DIV:   div_nxt = writedata[15:0];
        ADDR_TX_LO: tx_nxt[31:0] = writedata;
        ADDR_TX_HI: tx_nxt[FRAME_MAX_W-1:32] = writedata[FRAME_MAX_W-33:0];
        default: ;
      endcase
    end

    irq_nxt = done_nxt & irq_en_nxt;
  end

  // State registers with synchronous reset; reset mid-frame simply abandons it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      len_m1  <= '0;
      mask    <= '0;
      div     <= DIV_RST_V;
      tx      <= '0;
      div_lat <= DIV_RST_V;
      len_lat <= 7'd1;
      tx_sh   <= '0;
      hcnt    <= '0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      cs_n    <= '1;
      irq     <= 1'b0;
`ifdef LM96570_SPI_READBACK_EN
      rx      <= '0;
`endif
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      irq_en  <= irq_en_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      len_m1  <= len_m1_nxt;
      mask    <= mask_nxt;
      div     <= div_nxt;
      tx      <= tx_nxt;
      div_lat <= div_lat_nxt;
      len_lat <= len_lat_nxt;
      tx_sh   <= tx_sh_nxt;
      hcnt    <= hcnt_nxt;
      sclk    <= sclk_nxt;
      sdo     <= sdo_nxt;
      cs_n    <= cs_n_nxt;
      irq     <= irq_nxt;
`ifdef LM96570_SPI_READBACK_EN
      rx      <= rx_nxt;
`endif
    end
  end

  // Zero-wait combinational read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[STAT_BUSY]                  = busy;
        readdata[STAT_IRQ_EN]                = irq_en;
        readdata[STAT_DONE]                  = done;
        readdata[STAT_ERR]                   = err;
        readdata[CTRL_LEN_LSB +: 6]          = len_m1;
        readdata[CTRL_MASK_LSB +: NUM_CS]    = mask;
      end
      ADDR_DIV:   readdata[15:0] = div;
      ADDR_TX_LO: readdata = tx[31:0];
      ADDR_TX_HI: readdata = 32'(tx[FRAME_MAX_W-1:32]);
`ifdef LM96570_SPI_READBACK_EN
      ADDR_RX_LO: readdata = rx[31:0];
      ADDR_RX_HI: readdata = 32'(rx[FRAME_MAX_W-1:32]);
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lm96570_spi_master.sv
// Randomised and directed frames against a timing/bit model derived from the register rules.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_lm96570_spi_master;

  localparam int NCS  = 4;
  localparam int FMW  = 64;
  localparam int DRST = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      address = 3'd0;
  logic            chipselect = 1'b0;
  logic            write_n = 1'b1;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic            irq, sclk, sdo, sdi;
  logic [NCS-1:0]  cs_n;

  int checks = 0;
  int errors = 0;
  int rise_total = 0;
  logic sclk_d = 1'b0;

  assign sdi = sdo;

  always #5 clk = ~clk;

  lm96570_spi_master #(.NUM_CS(NCS), .FRAME_MAX_W(FMW), .DIV_RST(DRST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .sclk       (sclk),
    .sdo        (sdo),
    .sdi        (sdi),
    .cs_n       (cs_n)
  );

  // Independent count of every rising sclk edge seen on the pin
  always @(negedge clk) begin
    if (sclk && !sclk_d) rise_total++;
    sclk_d = sclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = 3'd0;
    #1;
  endtask

  function automatic logic [31:0] mk_ctrl(input logic s, input logic ie, input logic cl,
                                          input logic [5:0] lm1, input logic [NCS-1:0] m);
    logic [31:0] d;
    d = '0;
    d[0] = s; d[1] = ie; d[2] = cl;
    d[13:8] = lm1;
    d[16 +: NCS] = m;
    return d;
  endfunction

  // One complete frame: program, start with clear, then watch the pins every cycle
  task automatic run_frame(input int div, input int lm1, input logic [63:0] tx,
                           input logic [NCS-1:0] mask, input logic ien);
    int h, l, busy_cyc, rises, bad_pos, bad_cs, cs_low, irq_early;
    logic prev;
    logic [63:0] sdo_bits, lmask;
    logic [31:0] d;
    h = div + 1;
    l = (lm1 + 1 > FMW) ? FMW : lm1 + 1;
    lmask = (64'd1 << l) - 64'd1;
    busy_cyc = 0; rises = 0; bad_pos = 0; bad_cs = 0; cs_low = 0; irq_early = 0;
    sdo_bits = '0;
    wr(3'd1, 32'(div));
    wr(3'd2, tx[31:0]);
    wr(3'd3, tx[63:32]);
    wr(3'd0, mk_ctrl(1'b1, ien, 1'b1, 6'(lm1), mask));
    prev = sclk;
    for (int c = 0; c < 3000; c++) begin
      if (!readdata[0]) break;
      busy_cyc++;
      if (sclk && !prev) begin
        if (c != h + 2 * h * rises) bad_pos++;
        if (rises < 64) sdo_bits[rises] = sdo;
        rises++;
      end
      if (cs_n != '1) begin
        cs_low++;
        if (cs_n != ~mask) bad_cs++;
      end
      if (irq) irq_early++;
      prev = sclk;
      cyc();
    end
    chk("busy_len", 64'(busy_cyc), 64'(h * (2 * l + 2)));
    chk("rise_cnt", 64'(rises), 64'(l));
    chk("rise_pos", 64'(bad_pos), 64'd0);
    chk("sdo_bits", sdo_bits & lmask, tx & lmask);
    chk("cs_low_len", 64'(cs_low), 64'(h * (2 * l + 1)));
    chk("cs_pattern", 64'(bad_cs), 64'd0);
    chk("irq_early", 64'(irq_early), 64'd0);
    chk("done_at_end", 64'(readdata[2]), 64'd1);
    chk("err_at_end", 64'(readdata[3]), 64'd0);
    chk("irq_at_end", 64'(irq), 64'(ien));
    chk("cs_idle", 64'(cs_n), 64'hF);
`ifdef LM96570_SPI_READBACK_EN
    rd(3'd4, d);
    chk("rx_lo", 64'(d), (tx & lmask) & 64'hFFFF_FFFF);
    rd(3'd5, d);
    chk("rx_hi", 64'(d), (tx & lmask) >> 32);
`else
    rd(3'd4, d);
    chk("rx_lo_absent", 64'(d), 64'd0);
`endif
  endtask

  initial begin
    logic [31:0] d;
    int r0, bcnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", 64'(readdata), 64'd0);
    chk("rst_cs_n", 64'(cs_n), 64'hF);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    reset_n = 1'b1;
    cyc();
    rd(3'd1, d); chk("rst_div", 64'(d), 64'(DRST));
    rd(3'd2, d); chk("rst_tx_lo", 64'(d), 64'd0);
    rd(3'd3, d); chk("rst_tx_hi", 64'(d), 64'd0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, d); chk("addr6_zero", 64'(d), 64'd0);

    // Directed frames
    run_frame(0, 7, 64'hA5, 4'h1, 1'b0);
    run_frame(3, 63, 64'h0123_4567_89AB_CDEF, 4'hF, 1'b0);
    run_frame(1, 39, {$urandom, $urandom}, 4'h6, 1'b0);

    // Randomised frames
    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), {$urandom, $urandom},
                4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    // START while busy, and DIV write while busy
    wr(3'd1, 32'd1);
    wr(3'd2, 32'h0000_00C3);
    r0 = rise_total;
    wr(3'd0, mk_ctrl(1'b1, 1'b0, 1'b1, 6'd7, 4'h1));
    cyc(); cyc();
    wr(3'd0, mk_ctrl(1'b1, 1'b0, 1'b0, 6'd7, 4'h1));
    chk("busy_start_err", 64'(readdata[3]), 64'd1);
    wr(3'd1, 32'd5);
    bcnt = 0;
    for (int c = 0; c < 500; c++) begin
      if (!readdata[0]) break;
      bcnt++;
      cyc();
    end
    chk("busy_start_len", 64'(bcnt), 64'd32);
    chk("busy_start_done", 64'(readdata[2]), 64'd1);
    repeat (30) cyc();
    chk("no_extra_frame", 64'(rise_total - r0), 64'd8);
    chk("no_restart", 64'(readdata[0]), 64'd0);
    rd(3'd1, d); chk("div_locked", 64'(d), 64'd1);
    wr(3'd0, mk_ctrl(1'b0, 1'b0, 1'b1, 6'd7, 4'h1));
    chk("clear_err", 64'(readdata[3:2]), 64'd0);

    // START with empty mask
    r0 = rise_total;
    wr(3'd0, mk_ctrl(1'b1, 1'b0, 1'b0, 6'd7, 4'h0));
    chk("zero_mask_err", 64'(readdata[3]), 64'd1);
    chk("zero_mask_idle", 64'(readdata[0]), 64'd0);
    repeat (10) cyc();
    chk("zero_mask_no_sclk", 64'(rise_total - r0), 64'd0);
    chk("zero_mask_cs", 64'(cs_n), 64'hF);
    wr(3'd0, mk_ctrl(1'b0, 1'b0, 1'b1, 6'd7, 4'h0));
    chk("zero_mask_clear", 64'(readdata[3]), 64'd0);

    // Interrupt raise and clear
    run_frame(2, 11, {$urandom, $urandom}, 4'h9, 1'b1);
    wr(3'd0, mk_ctrl(1'b0, 1'b1, 1'b1, 6'd11, 4'h9));
    chk("irq_cleared", 64'(irq), 64'd0);
    chk("done_cleared", 64'(readdata[2]), 64'd0);

    // Reset mid-SHIFT, DONE/IRQ left set beforehand
    run_frame(0, 3, 64'h5, 4'h2, 1'b1);
    wr(3'd1, 32'd3);
    wr(3'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 6'd15, 4'hF));
    repeat (10) cyc();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_sclk", 64'(sclk), 64'd0);
    chk("mid_rst_cs", 64'(cs_n), 64'hF);
    chk("mid_rst_busy", 64'(readdata[0]), 64'd0);
    chk("mid_rst_done", 64'(readdata[2]), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    rd(3'd1, d); chk("mid_rst_div", 64'(d), 64'(DRST));
    @(negedge clk);
    reset_n = 1'b1;
    r0 = rise_total;
    repeat (20) cyc();
    chk("post_rst_quiet", 64'(rise_total - r0), 64'd0);
    chk("post_rst_cs", 64'(cs_n), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
